mult_unit: RTL
==============

# mult_unit

Iterative unsigned multiplier with architectural HI/LO registers for the MIPS datapath; it consumes the `mult_enable`, `sfmux_high` and `sf2reg` controls produced by the ALU auxiliary decoder. MULTU starts a 32-step shift-add multiply. MFHI/MFLO read the selected special register through `sf_out`. `stall` holds the pipeline whenever an instruction would observe or disturb an in-flight multiply.

## Interface
- `WIDTH`, 32, operand width; product is 2×WIDTH, split into HI (upper) and LO (lower).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `mult_enable`  in  1  MULTU decoded in the current cycle; request to start.
- `sf2reg`  in  1  MFHI/MFLO decoded; the instruction writes `sf_out` to the register file.
- `sfmux_high`  in  1  1 selects HI, 0 selects LO, on `sf_out`.
- `a`  in  WIDTH  multiplicand (rs).
- `b`  in  WIDTH  multiplier (rt).
- `sf_out`  out  WIDTH  combinational `sfmux_high ? HI : LO`.
- `busy`  out  1  a multiply is in progress.
- `done`  out  1  one-cycle pulse; HI/LO were just updated.
- `stall`  out  1  combinational `busy & (mult_enable | sf2reg)`.

## Operation
- State machine with three states: IDLE, RUN, DONE.
  - IDLE/DONE → RUN when `mult_enable` is 1 at a clock edge.
  - RUN → DONE when the step counter reaches its last step.
  - DONE → IDLE when `mult_enable` is 0.
  - A start is accepted in DONE exactly as in IDLE, so back-to-back MULTU is allowed.
- On start:
  - multiplicand register M ← `a`.
  - product register P (2×WIDTH) ← {WIDTH'b0, `b`}.
  - counter ← WIDTH.
- Each RUN cycle:
  - sum = P[2W-1:W] + (P[0] ? M : 0), computed at WIDTH+1 bits (carry kept).
  - P ← {sum, P[W-1:1]}, i.e. a logical right shift with the carry as the new MSB.
  - counter decrements by 1.
- Final RUN step (counter == 1):
  - The shifted P is written to {HI, LO} on the same edge.
  - State moves to DONE.
- HI/LO are written only on completion. They hold their previous values for the whole of RUN, so a partial product is never visible.
- `mult_enable` while in RUN is ignored. `stall` is asserted in that case, so the pipeline re-presents the MULTU after completion.
- MFHI/MFLO while in RUN: `stall` is asserted, and `sf_out` shows the old HI/LO. This output is not captured because the pipeline is stalled.
- The multiply is fully unsigned. No overflow condition exists, since the product always fits in 2×WIDTH bits.
- `a` and `b` are sampled only on the start edge. Later changes to them have no effect.

## Timing
- Reset, when `rst_n` = 0 at an edge:
  - state = IDLE, HI = 0, LO = 0, P = 0, M = 0, counter = 0.
  - `busy` = 0, `done` = 0, and hence `stall` = 0.
  - `sf_out` = 0.
- Reset overrides everything. Reset during RUN aborts the multiply and clears HI/LO; there is no partial write.
- Start sampled at edge k:
  - `busy` = 1 in cycles k+1 … k+WIDTH (32 cycles).
  - HI/LO hold the new product from edge k+WIDTH onward.
  - `done` = 1 in the cycle after edge k+WIDTH only.
  - `busy` = 0 in the `done` cycle.
- Latency from start to a readable result is WIDTH cycles. MFHI issued in the `done` cycle gets the new value with no stall.
- `busy` and `done` are registered (decoded from state). `stall` and `sf_out` are combinational from registered state and the current inputs.
- Start and reset asserted in the same cycle: reset wins.

## Test plan
- Basic product: reset, then `a`=3, `b`=5, `mult_enable` pulse.
  - `busy` stays high for exactly 32 cycles, then `done` pulses.
  - HI=0x00000000, LO=0x0000000F.
- Max operands: `a`=`b`=0xFFFFFFFF.
  - HI=0xFFFFFFFE, LO=0x00000001.
  - `sf_out` matches each value as `sfmux_high` toggles.
- Read during multiply: start 0x00010000 × 0x00010000 with prior HI/LO = 0. Assert `sf2reg`=1, `sfmux_high`=1 on cycle k+5.
  - `stall`=1 through cycle k+32.
  - `sf_out`=0 until edge k+32, then `sf_out`=0x00000001 with `stall`=0.
- Ignored restart: start 7×9, then pulse `mult_enable` with `a`=`b`=2 at cycle k+10.
  - `stall`=1 in that cycle.
  - The result is HI=0, LO=0x0000003F.
  - No second `done` is produced without a new accepted start.
- Back-to-back: hold `mult_enable` during the `done` cycle with 0xFFFFFFFF × 2.
  - A second run starts immediately.
  - After 32 more cycles, HI=0x00000001, LO=0xFFFFFFFE.
- Reset mid-operation: start 0x12345678 × 0x9ABCDEF0 with HI/LO preloaded nonzero, then drop `rst_n` at cycle k+16.
  - Next cycle: `busy`=0, `done`=0, HI=LO=0.
  - No `done` pulse is produced afterward.

Source files
------------

// File: rtl/mult_unit.sv
// Iterative 32-step shift-add unsigned multiplier with architectural HI/LO registers.
// HI/LO change only on the completing edge, so readers never see a partial product.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mult_enable,
    input  logic             sf2reg,
    input  logic             sfmux_high,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sf_out,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [2*WIDTH-1:0] p_q;
    logic [2*WIDTH-1:0] p_d;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH:0]     sum_s;

    // One shift-add step: add the multiplicand into the upper half when the LSB is set, keep the carry.
    always_comb begin
        sum_s = {1'b0, p_q[2*WIDTH-1:WIDTH]};
        if (p_q[0]) begin
            sum_s = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
        end else begin
            sum_s = {1'b0, p_q[2*WIDTH-1:WIDTH]};
        end
        p_d = {sum_s, p_q[WIDTH-1:1]};
    end

    // Sequencer, datapath registers and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= {(2*WIDTH){1'b0}};
            m_q     <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (mult_enable) begin
                        m_q     <= a;
                        p_q     <= {{WIDTH{1'b0}}, b};
                        cnt_q   <= CW'(WIDTH);
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        hi_q    <= p_d[2*WIDTH-1:WIDTH];
                        lo_q    <= p_d[WIDTH-1:0];
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign stall  = busy_q & (mult_enable | sf2reg);
    assign sf_out = sfmux_high ? hi_q : lo_q;

endmodule
